// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the instruction-memory handshake, applies EX redirects.
// Latency: a word returned in cycle N appears on if_id_* in cycle N+1; memory outputs are combinational from state.
// Backpressure: stall_i freezes PC and IF/ID; a word returned under stall is parked in a buffer until release.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h6000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic [1:0]  pcmux_sel,
   input  logic [31:0] target_addr,
   output logic [31:0] instr_mem_address,
   output logic        instr_mem_read,
   input  logic [31:0] instr_mem_rdata,
   input  logic        instr_mem_resp,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_ir,
   output logic        fetch_pending
);

   // pcmux encodings; 2'b11 falls through as pc_plus4
   localparam logic [1:0] PCMUX_ADDER_OUT  = 2'b01;
   localparam logic [1:0] PCMUX_ADDER_MOD2 = 2'b10;

   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_HOLD  = 2'b01;
   localparam logic [1:0] ST_DRAIN = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_buf_q, hold_buf_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_ir_q, if_id_ir_d;

   logic        redirect;
   logic [31:0] redirect_pc;

   // Decode the EX redirect; JALR clears bit 0, other low bits pass through unchecked
   always_comb begin
      redirect    = (pcmux_sel == PCMUX_ADDER_OUT) | (pcmux_sel == PCMUX_ADDER_MOD2);
      redirect_pc = (pcmux_sel == PCMUX_ADDER_MOD2) ? (target_addr & ~32'h1) : target_addr;
   end

   // Memory-side outputs depend only on state/pc (and reset gating), never on resp
   always_comb begin
      instr_mem_read    = rst_n & ((state_q == ST_FETCH) | (state_q == ST_DRAIN));
      instr_mem_address = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
      fetch_pending     = instr_mem_read & ~instr_mem_resp;
   end

   // Next-state logic: stall has priority; a redirect mid-request drains the abandoned fetch
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      hold_buf_d    = hold_buf_q;
      drain_addr_d  = drain_addr_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_ir_d    = if_id_ir_q;
      case (state_q)
         ST_FETCH: begin
            if (stall_i) begin
               if (instr_mem_resp) begin
                  hold_buf_d = instr_mem_rdata;
                  state_d    = ST_HOLD;
               end
            end else if (redirect) begin
               pc_d          = redirect_pc;
               if_id_valid_d = 1'b0;
               if_id_pc_d    = 32'h0;
               if_id_ir_d    = NOP_INSTR;
               if (!instr_mem_resp) begin
                  state_d      = ST_DRAIN;
                  drain_addr_d = pc_q;
               end
            end else if (instr_mem_resp) begin
               if_id_valid_d = 1'b1;
               if_id_pc_d    = pc_q;
               if_id_ir_d    = instr_mem_rdata;
               pc_d          = pc_q + 32'd4;
            end else begin
               if_id_valid_d = 1'b0;
               if_id_pc_d    = 32'h0;
               if_id_ir_d    = NOP_INSTR;
            end
         end
         ST_HOLD: begin
            if (!stall_i) begin
               state_d = ST_FETCH;
               if (redirect) begin
                  pc_d          = redirect_pc;
                  if_id_valid_d = 1'b0;
                  if_id_pc_d    = 32'h0;
                  if_id_ir_d    = NOP_INSTR;
               end else begin
                  if_id_valid_d = 1'b1;
                  if_id_pc_d    = pc_q;
                  if_id_ir_d    = hold_buf_q;
                  pc_d          = pc_q + 32'd4;
               end
            end
         end
         ST_DRAIN: begin
            if (!stall_i) begin
               if_id_valid_d = 1'b0;
               if_id_pc_d    = 32'h0;
               if_id_ir_d    = NOP_INSTR;
               if (redirect) begin
                  pc_d = redirect_pc;
               end
            end
            if (instr_mem_resp) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // State and IF/ID registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         hold_buf_q    <= 32'h0;
         drain_addr_q  <= 32'h0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= 32'h0;
         if_id_ir_q    <= NOP_INSTR;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         hold_buf_q    <= hold_buf_d;
         drain_addr_q  <= drain_addr_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_ir_q    <= if_id_ir_d;
      end
   end

   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_ir    = if_id_ir_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h6000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic [1:0]  pcmux_sel;
   logic [31:0] target_addr;
   logic [31:0] instr_mem_address;
   logic        instr_mem_read;
   logic [31:0] instr_mem_rdata;
   logic        instr_mem_resp;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_ir;
   logic        fetch_pending;

   fetch_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall_i           (stall_i),
      .pcmux_sel         (pcmux_sel),
      .target_addr       (target_addr),
      .instr_mem_address (instr_mem_address),
      .instr_mem_read    (instr_mem_read),
      .instr_mem_rdata   (instr_mem_rdata),
      .instr_mem_resp    (instr_mem_resp),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_ir          (if_id_ir),
      .fetch_pending     (fetch_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: fetch pointer, a parked word, an abandoned request still in flight
   logic [31:0] m_pc;
   logic        m_parked;
   logic [31:0] m_parked_word;
   logic        m_abandoned;
   logic [31:0] m_abandon_addr;
   logic        m_v;
   logic [31:0] m_ipc;
   logic [31:0] m_ir;
   // Memory model: latency in cycles, cycles already spent on current request
   int          lat;
   int          mem_cnt;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc           = RST_PC;
      m_parked       = 1'b0;
      m_parked_word  = 32'h0;
      m_abandoned    = 1'b0;
      m_abandon_addr = 32'h0;
      m_v            = 1'b0;
      m_ipc          = 32'h0;
      m_ir           = NOP;
      mem_cnt        = 0;
   endtask

   task automatic model_bubble();
      m_v   = 1'b0;
      m_ipc = 32'h0;
      m_ir  = NOP;
   endtask

   // One clock cycle: called at a negedge, returns at the next negedge
   task automatic do_cycle(input logic st, input logic [1:0] sel, input logic [31:0] tgt);
      logic        e_read;
      logic [31:0] e_addr;
      logic        rsp;
      logic        redir;
      logic [31:0] rpc;
      e_read = !m_parked;
      e_addr = m_abandoned ? m_abandon_addr : m_pc;
      rsp    = e_read && (mem_cnt >= lat - 1);
      stall_i         = st;
      pcmux_sel       = sel;
      target_addr     = tgt;
      instr_mem_resp  = rsp;
      instr_mem_rdata = rsp ? word_at(e_addr) : 32'hDEAD_BEEF;
      #1;
      check("mem_read", {31'h0, instr_mem_read}, {31'h0, e_read});
      if (e_read) check("mem_addr", instr_mem_address, e_addr);
      check("fetch_pending", {31'h0, fetch_pending}, {31'h0, e_read & ~rsp});
      @(posedge clk);
      redir = (sel == 2'b01) || (sel == 2'b10);
      rpc   = (sel == 2'b10) ? {tgt[31:1], 1'b0} : tgt;
      if (e_read) mem_cnt = rsp ? 0 : mem_cnt + 1;
      if (m_parked) begin
         if (!st) begin
            if (redir) begin
               model_bubble();
               m_pc = rpc;
            end else begin
               m_v = 1'b1; m_ipc = m_pc; m_ir = m_parked_word;
               m_pc = m_pc + 32'd4;
            end
            m_parked = 1'b0;
         end
      end else if (m_abandoned) begin
         if (!st) begin
            model_bubble();
            if (redir) m_pc = rpc;
         end
         if (rsp) m_abandoned = 1'b0;
      end else begin
         if (st) begin
            if (rsp) begin
               m_parked = 1'b1;
               m_parked_word = word_at(e_addr);
            end
         end else if (redir) begin
            model_bubble();
            if (!rsp) begin
               m_abandoned = 1'b1;
               m_abandon_addr = m_pc;
            end
            m_pc = rpc;
         end else if (rsp) begin
            m_v = 1'b1; m_ipc = m_pc; m_ir = word_at(e_addr);
            m_pc = m_pc + 32'd4;
         end else begin
            model_bubble();
         end
      end
      #1;
      check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_v});
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_ir", if_id_ir, m_ir);
      @(negedge clk);
   endtask

   initial begin
      int r;
      logic [1:0] sel;
      rst_n = 1'b0;
      stall_i = 1'b0;
      pcmux_sel = 2'b00;
      target_addr = 32'h0;
      instr_mem_rdata = 32'h0;
      instr_mem_resp = 1'b0;
      lat = 1;
      model_reset();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_read", {31'h0, instr_mem_read}, 32'h0);
      check("rst_valid", {31'h0, if_id_valid}, 32'h0);
      check("rst_ir", if_id_ir, NOP);
      check("rst_pc", if_id_pc, 32'h0);
      rst_n = 1'b1;

      // Zero-wait streaming
      #1;
      check("first_addr", instr_mem_address, RST_PC);
      for (int i = 0; i < 4; i++) do_cycle(1'b0, 2'b00, 32'h0);
      check("stream_pc_after4", m_ipc, RST_PC + 32'hC);

      // 3-cycle latency
      lat = 3;
      for (int i = 0; i < 9; i++) do_cycle(1'b0, 2'b00, 32'h0);

      // JALR redirect with zero-wait memory
      lat = 1;
      do_cycle(1'b0, 2'b00, 32'h0);
      do_cycle(1'b0, 2'b10, 32'h6000_0101);
      check("jalr_next_addr", instr_mem_address, 32'h6000_0100);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, 32'h0);

      // Redirect two cycles into a 3-cycle request
      lat = 3;
      for (int i = 0; i < 10 && !(mem_cnt == 1 && !m_abandoned && !m_parked); i++)
         do_cycle(1'b0, 2'b00, 32'h0);
      do_cycle(1'b0, 2'b01, 32'h6000_0200);
      for (int i = 0; i < 6; i++) do_cycle(1'b0, 2'b00, 32'h0);

      // Stall 4 cycles, response on the first stall cycle
      lat = 1;
      do_cycle(1'b0, 2'b00, 32'h0);
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 2'b00, 32'h0);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, 32'h0);

      // Stall with redirect together, then redirect right after release
      for (int i = 0; i < 2; i++) do_cycle(1'b1, 2'b01, 32'h6000_0400);
      do_cycle(1'b0, 2'b01, 32'h6000_0400);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, 32'h0);

      // Randomized run
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
         r = $urandom_range(0, 9);
         sel = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
         do_cycle($urandom_range(0, 3) == 0, sel, $urandom);
      end

      // Asynchronous reset in the middle of a request
      lat = 3;
      for (int i = 0; i < 10 && !(mem_cnt == 1 && !m_parked); i++)
         do_cycle(1'b0, 2'b00, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_read", {31'h0, instr_mem_read}, 32'h0);
      check("arst_valid", {31'h0, if_id_valid}, 32'h0);
      check("arst_ir", if_id_ir, NOP);
      check("arst_pc", if_id_pc, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 2'b00, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
